// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fetch_queue_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- shown to decode whenever no instruction is held
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One buffered fetch: the returned word and the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low two bits are dropped
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: imem request/response, execute redirect and decode handshake.
// Latency: n/a (wiring only).
// Backpressure: ReadyD low from decode stalls the head of the fetch queue.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic [XLEN-1:0] ImemRData;
  logic            Redirect;
  logic [XLEN-1:0] RedirectPC;
  logic            ValidD;
  logic            ReadyD;
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;

  // Fetch stage side
  modport master (
    output ImemReq, ImemAddr,
    input  ImemRData,
    input  Redirect, RedirectPC,
    output ValidD,
    input  ReadyD,
    output InstrD, PCD, PCPlus4D
  );

  // Environment side: instruction memory, execute and decode
  modport slave (
    input  ImemReq, ImemAddr,
    output ImemRData,
    output Redirect, RedirectPC,
    input  ValidD,
    output ReadyD,
    input  InstrD, PCD, PCPlus4D
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Small register FIFO of fetch entries with synchronous flush.
// Latency: push visible at head on the next cycle; pop advances head on the next edge.
// Backpressure: push ignored when full unless a pop frees a slot in the same cycle.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_dat,
  input  logic                     i_pop,
  output fetch_entry_t             o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_pop   = i_pop & ~o_empty;
  // A full queue can still accept a push when the head leaves in the same cycle
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_head_dat = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; flush returns to empty
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; slots are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (w_push && !reset && !i_clr) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/fetch_queue.sv
// RV32I fetch stage: owns PCF, requests synchronous imem, queues words for decode.
// Latency: request in cycle 0, ValidD in cycle 2; 1 instr/cycle in steady state.
// Backpressure: ReadyD low holds the head; issue stops when queued+in-flight hits DEPTH.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0]   OCC_LIMIT = (AW + 2)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;

  logic            w_pop;
  logic            w_issue;
  logic            w_empty;
  logic [AW:0]     w_count;
  logic [AW+1:0]   w_occ_after_pop;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_dat;

  // Head leaves when decode accepts it
  assign w_pop = bus.ValidD & bus.ReadyD;

  // Slots that stay committed after this cycle's pop: queued plus the outstanding fetch.
  // Never underflows because a pop implies at least one queued entry.
  assign w_occ_after_pop = {1'b0, w_count}
                         + {{(AW + 1){1'b0}}, r_inflight}
                         - {{(AW + 1){1'b0}}, w_pop};

  // Only fetch when the response is guaranteed a slot; a redirect owns the cycle
  assign w_issue = !reset && !bus.Redirect && (w_occ_after_pop < OCC_LIMIT);

  // The response always lands the cycle after its request; it is tagged with that PC
  assign w_push_dat = '{instr: bus.ImemRData, pc: r_inflight_pc};

  fetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (bus.Redirect),
    .i_push     (r_inflight),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_empty    (w_empty)
  );

  // PC sequencing and in-flight tracking; redirect drops the outstanding fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcf         <= word_align(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.Redirect) begin
      r_pcf         <= word_align(bus.RedirectPC);
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pcf         <= r_pcf + PC_STEP;
        r_inflight_pc <= r_pcf;
      end
    end
  end

  assign bus.ImemReq  = w_issue;
  assign bus.ImemAddr = r_pcf;

  // Decode outputs come straight from queue registers; idle shows a NOP at PC 0
  assign bus.ValidD   = ~w_empty;
  assign bus.InstrD   = w_empty ? NOP_INSTR : w_head.instr;
  assign bus.PCD      = w_empty ? '0        : w_head.pc;
  assign bus.PCPlus4D = w_empty ? '0        : w_head.pc + PC_STEP;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table plus randomized stream checking.
// Latency: n/a.
// Backpressure: ReadyD driven from the table and randomly.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if bus ();

  fetch_queue #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory contents: the word at byte address 4*i holds i
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  // Synchronous instruction memory; garbage when not requested
  always @(posedge clk)
    bus.ImemRData <= bus.ImemReq ? word_at(bus.ImemAddr) : 32'hDEAD_BEEF;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the architectural instruction stream since the last flush.
  // Fetches and decode acceptances walk that stream in order from the flush target.
  logic [31:0] m_target = 32'h0;
  int          m_issued = 0;
  int          m_popped = 0;
  int          m_since  = 0;

  // Outputs sampled in the most recent step
  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pcd, s_instr, s_p4;

  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          e_vld, e_req, pop_m;
    logic [31:0] e_pc;
    @(negedge clk);
    reset          = rst;
    bus.Redirect   = redir;
    bus.RedirectPC = rpc;
    bus.ReadyD     = rdy;
    #1;
    s_req   = bus.ImemReq;
    s_addr  = bus.ImemAddr;
    s_vld   = bus.ValidD;
    s_pcd   = bus.PCD;
    s_instr = bus.InstrD;
    s_p4    = bus.PCPlus4D;

    e_vld = (m_since >= 3);
    pop_m = e_vld & rdy;
    e_req = !rst && !redir && ((m_issued - m_popped - int'(pop_m)) < DEPTH);

    check("model ImemReq", {31'b0, s_req}, {31'b0, e_req});
    if (e_req) check("model ImemAddr", s_addr, m_target + 32'(4 * m_issued));
    if (!rst) begin
      check("model ValidD", {31'b0, s_vld}, {31'b0, e_vld});
      if (e_vld) begin
        e_pc = m_target + 32'(4 * m_popped);
        check("model PCD", s_pcd, e_pc);
        check("model InstrD", s_instr, word_at(e_pc));
        check("model PCPlus4D", s_p4, e_pc + 32'd4);
      end
    end

    @(posedge clk);
    if (rst) begin
      m_target = RESET_PC;
      m_issued = 0;
      m_popped = 0;
      m_since  = 1;
    end else if (redir) begin
      m_target = {rpc[31:2], 2'b00};
      m_issued = 0;
      m_popped = 0;
      m_since  = 1;
    end else begin
      if (e_req) m_issued++;
      if (pop_m) m_popped++;
      if (m_since < 3) m_since++;
    end
  endtask

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_vld;
    logic [31:0] e_pcd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit redir, logic [31:0] rpc, bit rdy,
                              bit e_req, logic [31:0] e_addr, bit e_vld, logic [31:0] e_pcd);
    vecs.push_back('{rst, redir, rpc, rdy, e_req, e_addr, e_vld, e_pcd});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = '0;
    bus.ReadyD     = 1'b1;

    // Straight-line fetch from reset
    add(0,0,0,1, 1,32'h00, 0,0);
    add(0,0,0,1, 1,32'h04, 0,0);
    add(0,0,0,1, 1,32'h08, 1,32'h00);
    add(0,0,0,1, 1,32'h0C, 1,32'h04);
    add(0,0,0,1, 1,32'h10, 1,32'h08);
    add(0,0,0,1, 1,32'h14, 1,32'h0C);
    add(1,0,0,1, 0,0, 0,0);
    add(1,0,0,1, 0,0, 0,0);
    // Stall from the first valid instruction
    add(0,0,0,0, 1,32'h00, 0,0);
    add(0,0,0,0, 1,32'h04, 0,0);
    for (int k = 0; k < 5; k++) add(0,0,0,0, 0,0, 1,32'h00);
    add(0,0,0,1, 1,32'h08, 1,32'h00);
    add(0,0,0,1, 1,32'h0C, 1,32'h04);
    add(0,0,0,1, 1,32'h10, 1,32'h08);
    // Fill the queue, then redirect with a fetch outstanding
    add(0,0,0,0, 0,0, 1,32'h0C);
    add(0,0,0,1, 1,32'h14, 1,32'h0C);
    add(0,1,32'h100,1, 0,0, 1,32'h10);
    add(0,0,0,1, 1,32'h100, 0,0);
    add(0,0,0,1, 1,32'h104, 0,0);
    add(0,0,0,1, 1,32'h108, 1,32'h100);
    add(0,0,0,1, 1,32'h10C, 1,32'h104);
    // Back-to-back redirects: last one wins
    add(0,1,32'h200,1, 0,0, 1,32'h108);
    add(0,1,32'h300,1, 0,0, 0,0);
    add(0,0,0,1, 1,32'h300, 0,0);
    add(0,0,0,1, 1,32'h304, 0,0);
    add(0,0,0,1, 1,32'h308, 1,32'h300);
    // Misaligned redirect target
    add(0,1,32'h402,1, 0,0, 1,32'h304);
    add(0,0,0,1, 1,32'h400, 0,0);
    add(0,0,0,1, 1,32'h404, 0,0);
    add(0,0,0,1, 1,32'h408, 1,32'h400);
    // Reset mid-stream
    add(1,0,0,1, 0,0, 0,0);
    add(0,0,0,1, 1,32'h00, 0,0);
    add(0,0,0,1, 1,32'h04, 0,0);
    add(0,0,0,1, 1,32'h08, 1,32'h00);
    // PC wrap at the top of the address space
    add(0,1,32'hFFFF_FFFC,1, 0,0, 1,32'h04);
    add(0,0,0,1, 1,32'hFFFF_FFFC, 0,0);
    add(0,0,0,1, 1,32'h0000_0000, 0,0);
    add(0,0,0,1, 1,32'h04, 1,32'hFFFF_FFFC);
    add(0,0,0,1, 1,32'h08, 1,32'h0000_0000);

    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    @(negedge clk);
    #1;
    check("reset ValidD",   {31'b0, bus.ValidD},  32'd0);
    check("reset ImemReq",  {31'b0, bus.ImemReq}, 32'd0);
    check("reset InstrD",   bus.InstrD,   32'h0000_0013);
    check("reset PCD",      bus.PCD,      32'h0);
    check("reset PCPlus4D", bus.PCPlus4D, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
      check($sformatf("row%0d ImemReq", i), {31'b0, s_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) check($sformatf("row%0d ImemAddr", i), s_addr, vecs[i].e_addr);
      if (!vecs[i].rst) begin
        check($sformatf("row%0d ValidD", i), {31'b0, s_vld}, {31'b0, vecs[i].e_vld});
        if (vecs[i].e_vld) begin
          check($sformatf("row%0d PCD", i), s_pcd, vecs[i].e_pcd);
          check($sformatf("row%0d InstrD", i), s_instr, word_at(vecs[i].e_pcd));
          check($sformatf("row%0d PCPlus4D", i), s_p4, vecs[i].e_pcd + 32'd4);
        end
      end
    end

    // Randomized traffic with stalls, redirects (some near the wrap point) and resets
    for (int c = 0; c < 3000; c++) begin
      bit          r_rst, r_redir, r_rdy;
      logic [31:0] r_pc;
      r_rst   = ($urandom_range(0, 99) == 0);
      r_redir = ($urandom_range(0, 15) == 0);
      r_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                            : $urandom;
      r_rdy   = ($urandom_range(0, 9) < 7);
      step(r_rst, r_redir, r_pc, r_rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
